// File: rtl/timer_counter_pkg.sv
// Shared definitions for the timer/counter: counting-mode encodings,
// direction constants and the raw-mode decoder.
package timer_counter_pkg;

  typedef enum logic [1:0] {
    MODE_UP     = 2'd0,
    MODE_DOWN   = 2'd1,
    MODE_CENTER = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_e;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // The reserved encoding behaves as an up counter.
  function automatic mode_e decode_mode(input logic [1:0] raw);
    mode_e m;
    case (raw)
      2'd1:    m = MODE_DOWN;
      2'd2:    m = MODE_CENTER;
      default: m = MODE_UP;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/timer_counter_if.sv
// Control and status bundle of the timer/counter; the master drives the
// controls, the slave (the timer) drives the status.
interface timer_counter_if #(
  parameter int bitwidth           = 16,
  parameter int prescaler_bitwidth = 8,
  parameter int channels           = 2
);
  logic                           start;
  logic                           stop;
  logic [1:0]                     mode;
  logic                           autoreload;
  logic [prescaler_bitwidth-1:0]  prescaler;
  logic [bitwidth-1:0]            reload_value;
  logic [channels*bitwidth-1:0]   compare_values;
  logic                           counting;
  logic [bitwidth-1:0]            value;
  logic                           direction;
  logic                           overflow;
  logic                           underflow;
  logic [channels-1:0]            compare_match;
  logic [channels-1:0]            pwm;

  modport master (
    output start, stop, mode, autoreload, prescaler, reload_value, compare_values,
    input  counting, value, direction, overflow, underflow, compare_match, pwm
  );

  modport slave (
    input  start, stop, mode, autoreload, prescaler, reload_value, compare_values,
    output counting, value, direction, overflow, underflow, compare_match, pwm
  );
endinterface

// File: rtl/timer_counter_compare_channel.sv
// One compare/PWM channel: shadowed compare value, match pulse and PWM level,
// all aligned with the registered counter value.
module compare_channel #(
  parameter int bitwidth = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                load,
  input  logic [bitwidth-1:0] compare_value,
  input  logic                tick,
  input  logic                counting_next,
  input  logic [bitwidth-1:0] value_next,
  output logic                compare_match,
  output logic                pwm
);

  logic [bitwidth-1:0] cmp_r;
  logic [bitwidth-1:0] cmp_nxt_s;
  logic                match_r;
  logic                pwm_r;

  // Compare shadow that will be active alongside the next counter value.
  always_comb begin
    cmp_nxt_s = cmp_r;
    if (load) begin
      cmp_nxt_s = compare_value;
    end else begin
      cmp_nxt_s = cmp_r;
    end
  end

  // Shadow, match pulse and PWM level registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cmp_r   <= '0;
      match_r <= 1'b0;
      pwm_r   <= 1'b0;
    end else begin
      cmp_r   <= cmp_nxt_s;
      match_r <= tick && (value_next == cmp_nxt_s);
      pwm_r   <= counting_next && (value_next < cmp_nxt_s);
    end
  end

  assign compare_match = match_r;
  assign pwm           = pwm_r;

endmodule

// File: rtl/timer_counter.sv
// Prescaled up/down/centre-aligned timer with shadowed period, prescaler and
// mode, plus a bank of compare/PWM channels.
module timer_counter
  import timer_counter_pkg::*;
#(
  parameter int bitwidth           = 16,
  parameter int prescaler_bitwidth = 8,
  parameter int channels           = 2
) (
  input  logic            clock,
  input  logic            reset,
  timer_counter_if.slave  bus
);

  localparam logic [bitwidth-1:0]           VAL_ONE   = {{(bitwidth-1){1'b0}}, 1'b1};
  localparam logic [prescaler_bitwidth-1:0] PRESC_ONE = {{(prescaler_bitwidth-1){1'b0}}, 1'b1};

  logic                          start_q_r, stop_q_r;
  logic                          counting_r, direction_r, overflow_r, underflow_r;
  logic [bitwidth-1:0]           value_r, reload_r;
  logic [prescaler_bitwidth-1:0] presc_cnt_r, presc_r;
  mode_e                         mode_r;

  logic                          start_edge_s, stop_edge_s, start_ok_s;
  logic                          tick_s, update_s, load_s;
  logic                          counting_nxt_s, direction_nxt_s, overflow_nxt_s, underflow_nxt_s;
  logic [bitwidth-1:0]           value_nxt_s;
  logic [prescaler_bitwidth-1:0] presc_cnt_nxt_s;
  mode_e                         new_mode_s;
  logic [channels-1:0]           match_s, pwm_s;

  assign start_edge_s = bus.start && !start_q_r;
  assign stop_edge_s  = bus.stop && !stop_q_r;
  assign start_ok_s   = start_edge_s && (bus.reload_value != '0);
  assign new_mode_s   = decode_mode(bus.mode);

  // Next-state of the counter; stop beats start, start beats counting.
  always_comb begin
    counting_nxt_s  = counting_r;
    direction_nxt_s = direction_r;
    overflow_nxt_s  = 1'b0;
    underflow_nxt_s = 1'b0;
    value_nxt_s     = value_r;
    presc_cnt_nxt_s = presc_cnt_r;
    tick_s          = 1'b0;
    update_s        = 1'b0;
    load_s          = 1'b0;
    if (stop_edge_s) begin
      counting_nxt_s = 1'b0;
    end else if (start_ok_s) begin
      load_s          = 1'b1;
      counting_nxt_s  = 1'b1;
      presc_cnt_nxt_s = '0;
      if (new_mode_s == MODE_DOWN) begin
        value_nxt_s     = bus.reload_value;
        direction_nxt_s = DIR_DOWN;
      end else begin
        value_nxt_s     = '0;
        direction_nxt_s = DIR_UP;
      end
    end else if (counting_r) begin
      if (presc_cnt_r == presc_r) begin
        tick_s          = 1'b1;
        presc_cnt_nxt_s = '0;
        case (mode_r)
          MODE_DOWN: begin
            if (value_r == '0) begin
              underflow_nxt_s = 1'b1;
              update_s        = 1'b1;
              value_nxt_s     = bus.autoreload ? bus.reload_value : reload_r;
            end else begin
              value_nxt_s = value_r - VAL_ONE;
            end
          end
          MODE_CENTER: begin
            if (direction_r == DIR_UP) begin
              if (value_r == reload_r) begin
                overflow_nxt_s  = 1'b1;
                direction_nxt_s = DIR_DOWN;
                value_nxt_s     = reload_r - VAL_ONE;
              end else begin
                value_nxt_s = value_r + VAL_ONE;
              end
            end else begin
              if (value_r == '0) begin
                underflow_nxt_s = 1'b1;
                update_s        = 1'b1;
                direction_nxt_s = DIR_UP;
                value_nxt_s     = VAL_ONE;
              end else begin
                value_nxt_s = value_r - VAL_ONE;
              end
            end
          end
          default: begin
            if (value_r == reload_r) begin
              overflow_nxt_s = 1'b1;
              update_s       = 1'b1;
              value_nxt_s    = '0;
            end else begin
              value_nxt_s = value_r + VAL_ONE;
            end
          end
        endcase
        // A period boundary either reloads the shadows or ends a one-shot run.
        if (update_s) begin
          if (bus.autoreload) begin
            load_s          = 1'b1;
            direction_nxt_s = (new_mode_s == MODE_DOWN) ? DIR_DOWN : DIR_UP;
          end else begin
            counting_nxt_s = 1'b0;
            value_nxt_s    = (mode_r == MODE_DOWN) ? reload_r : '0;
          end
        end else begin
          load_s = 1'b0;
        end
      end else begin
        presc_cnt_nxt_s = presc_cnt_r + PRESC_ONE;
      end
    end else begin
      counting_nxt_s = 1'b0;
    end
  end

  // Counter state, status outputs, edge history and active shadows.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      start_q_r   <= 1'b0;
      stop_q_r    <= 1'b0;
      counting_r  <= 1'b0;
      direction_r <= DIR_UP;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
      value_r     <= '0;
      presc_cnt_r <= '0;
      presc_r     <= '0;
      reload_r    <= '0;
      mode_r      <= MODE_UP;
    end else begin
      start_q_r   <= bus.start;
      stop_q_r    <= bus.stop;
      counting_r  <= counting_nxt_s;
      direction_r <= direction_nxt_s;
      overflow_r  <= overflow_nxt_s;
      underflow_r <= underflow_nxt_s;
      value_r     <= value_nxt_s;
      presc_cnt_r <= presc_cnt_nxt_s;
      if (load_s) begin
        mode_r   <= new_mode_s;
        presc_r  <= bus.prescaler;
        reload_r <= bus.reload_value;
      end
    end
  end

  for (genvar i = 0; i < channels; i++) begin : g_ch
    compare_channel #(.bitwidth(bitwidth)) u_ch (
      .clock         (clock),
      .reset         (reset),
      .load          (load_s),
      .compare_value (bus.compare_values[i*bitwidth +: bitwidth]),
      .tick          (tick_s),
      .counting_next (counting_nxt_s),
      .value_next    (value_nxt_s),
      .compare_match (match_s[i]),
      .pwm           (pwm_s[i])
    );
  end

  assign bus.counting      = counting_r;
  assign bus.value         = value_r;
  assign bus.direction     = direction_r;
  assign bus.overflow      = overflow_r;
  assign bus.underflow     = underflow_r;
  assign bus.compare_match = match_s;
  assign bus.pwm           = pwm_s;

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter: a cycle-by-cycle vector table for up and
// centre modes plus hand sequences for one-shot, shadow reload and reset.
module tb_timer_counter;

  localparam int BW = 16;
  localparam int PW = 8;
  localparam int CH = 2;
  localparam logic [23:0] CORE_MASK = 24'hF0FFFF;

  typedef struct packed {
    logic        start;
    logic        stop;
    logic [1:0]  mode;
    logic [15:0] rl;
    logic [15:0] c1;
    logic        cnt;
    logic        dir;
    logic        ov;
    logic        un;
    logic [1:0]  m;
    logic [1:0]  p;
    logic [15:0] v;
  } vec_t;

  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  vec_t tab [25];
  logic [23:0] obs_s;

  always #5 clock = ~clock;

  timer_counter_if #(.bitwidth(BW), .prescaler_bitwidth(PW), .channels(CH)) bus ();

  timer_counter #(.bitwidth(BW), .prescaler_bitwidth(PW), .channels(CH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  assign obs_s = {bus.counting, bus.direction, bus.overflow, bus.underflow,
                  bus.compare_match, bus.pwm, bus.value};

  function automatic vec_t row(input logic st, input logic sp, input logic [1:0] md,
                               input logic [15:0] rl, input logic [15:0] c1,
                               input logic cnt, input logic dir, input logic ov, input logic un,
                               input logic [1:0] m, input logic [1:0] p, input logic [15:0] v);
    vec_t r;
    r = {st, sp, md, rl, c1, cnt, dir, ov, un, m, p, v};
    return r;
  endfunction

  function automatic logic [23:0] pack(input logic cnt, input logic dir, input logic ov,
                                       input logic un, input logic [1:0] m, input logic [1:0] p,
                                       input logic [15:0] v);
    return {cnt, dir, ov, un, m, p, v};
  endfunction

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%06h expected=%06h", name, act, exp);
    end
  endtask

  initial begin
    // Up, reload 4, compare0=2, compare1=5 (> reload): counting, stop, ignored starts.
    tab[0]  = row(1'b1, 1'b0, 2'd0, 16'd4, 16'd5, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b11, 16'd0);
    tab[1]  = row(1'b1, 1'b0, 2'd0, 16'd4, 16'd5, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b11, 16'd1);
    tab[2]  = row(1'b1, 1'b0, 2'd0, 16'd4, 16'd5, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 2'b10, 16'd2);
    tab[3]  = row(1'b1, 1'b0, 2'd0, 16'd4, 16'd5, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 16'd3);
    tab[4]  = row(1'b1, 1'b0, 2'd0, 16'd4, 16'd5, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 16'd4);
    tab[5]  = row(1'b1, 1'b0, 2'd0, 16'd4, 16'd5, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b11, 16'd0);
    tab[6]  = row(1'b1, 1'b0, 2'd0, 16'd4, 16'd5, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b11, 16'd1);
    tab[7]  = row(1'b0, 1'b0, 2'd0, 16'd4, 16'd5, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 2'b10, 16'd2);
    tab[8]  = row(1'b0, 1'b1, 2'd0, 16'd4, 16'd5, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 16'd2);
    tab[9]  = row(1'b0, 1'b0, 2'd0, 16'd4, 16'd5, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 16'd2);
    tab[10] = row(1'b1, 1'b1, 2'd0, 16'd4, 16'd5, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 16'd2);
    tab[11] = row(1'b0, 1'b0, 2'd0, 16'd4, 16'd5, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 16'd2);
    tab[12] = row(1'b1, 1'b0, 2'd0, 16'd0, 16'd5, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 16'd2);
    tab[13] = row(1'b0, 1'b0, 2'd0, 16'd0, 16'd5, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 16'd2);
    // Centre, reload 3, compare0=2, compare1=0.
    tab[14] = row(1'b1, 1'b0, 2'd2, 16'd3, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 16'd0);
    tab[15] = row(1'b0, 1'b0, 2'd2, 16'd3, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 16'd1);
    tab[16] = row(1'b0, 1'b0, 2'd2, 16'd3, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 16'd2);
    tab[17] = row(1'b0, 1'b0, 2'd2, 16'd3, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 16'd3);
    tab[18] = row(1'b0, 1'b0, 2'd2, 16'd3, 16'd0, 1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 2'b00, 16'd2);
    tab[19] = row(1'b0, 1'b0, 2'd2, 16'd3, 16'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b01, 16'd1);
    tab[20] = row(1'b0, 1'b0, 2'd2, 16'd3, 16'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 2'b01, 16'd0);
    tab[21] = row(1'b0, 1'b0, 2'd2, 16'd3, 16'd0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b01, 16'd1);
    tab[22] = row(1'b0, 1'b0, 2'd2, 16'd3, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 16'd2);
    tab[23] = row(1'b0, 1'b0, 2'd2, 16'd3, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 16'd3);
    tab[24] = row(1'b0, 1'b0, 2'd2, 16'd3, 16'd0, 1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 2'b00, 16'd2);

    bus.start          = 1'b0;
    bus.stop           = 1'b0;
    bus.mode           = 2'd0;
    bus.autoreload     = 1'b1;
    bus.prescaler      = 8'd0;
    bus.reload_value   = 16'd0;
    bus.compare_values = 32'd0;
    reset = 1'b1;
    #1 reset = 1'b0;
    #1 check("reset_state", obs_s, 24'h000000);
    repeat (2) @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < 25; i++) begin
      bus.start          = tab[i].start;
      bus.stop           = tab[i].stop;
      bus.mode           = tab[i].mode;
      bus.autoreload     = 1'b1;
      bus.prescaler      = 8'd0;
      bus.reload_value   = tab[i].rl;
      bus.compare_values = {tab[i].c1, 16'd2};
      @(posedge clock);
      #1 check($sformatf("tab[%0d]", i), obs_s,
               pack(tab[i].cnt, tab[i].dir, tab[i].ov, tab[i].un, tab[i].m, tab[i].p, tab[i].v));
    end

    // Restart (from centre) into down one-shot, prescaler 2, reload 3.
    bus.start      = 1'b1;
    bus.mode       = 2'd1;
    bus.autoreload = 1'b0;
    bus.prescaler  = 8'd2;
    bus.reload_value = 16'd3;
    for (int k = 0; k < 14; k++) begin
      logic [15:0] ev;
      logic        ec;
      @(posedge clock);
      #1 bus.start = 1'b0;
      ec = (k < 12);
      ev = (k < 12) ? 16'(3 - k / 3) : 16'd3;
      check($sformatf("down_oneshot[%0d]", k), obs_s,
            pack(ec, 1'b1, 1'b0, (k == 12), {(k == 9), (k == 3)},
                 {1'b0, ec && (ev < 16'd2)}, ev));
    end

    // Up periodic: reload changes 4 -> 7 mid-period, takes effect next period.
    bus.start        = 1'b1;
    bus.mode         = 2'd0;
    bus.autoreload   = 1'b1;
    bus.prescaler    = 8'd0;
    bus.reload_value = 16'd4;
    for (int k = 0; k < 14; k++) begin
      logic [15:0] ev;
      @(posedge clock);
      #1 bus.start = 1'b0;
      ev = (k < 5) ? 16'(k) : 16'((k - 5) % 8);
      check($sformatf("reload_change[%0d]", k), obs_s & CORE_MASK,
            pack(1'b1, 1'b0, (k == 5 || k == 13), 1'b0, 2'b00, 2'b00, ev) & CORE_MASK);
      if (k == 1) bus.reload_value = 16'd7;
    end

    // Asynchronous reset while counting at value 3.
    bus.start        = 1'b1;
    bus.reload_value = 16'd4;
    for (int k = 0; k < 4; k++) begin
      @(posedge clock);
      #1 bus.start = 1'b0;
      check($sformatf("pre_reset[%0d]", k), obs_s & CORE_MASK,
            pack(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 16'(k)) & CORE_MASK);
    end
    #2 reset = 1'b0;
    #1 check("async_reset", obs_s, 24'h000000);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clock);
      #1 check($sformatf("post_reset_idle[%0d]", k), obs_s, 24'h000000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/timer_counter.md
Name: timer_counter

Overview:
- Next-generation general-purpose timer/counter: prescaled up, down or centre-aligned counting, shadowed reload/compare registers, N compare channels with match pulses and PWM outputs.
- Replaces the single-mode up counter in timing, PWM and periodic-event paths.
- Feeds motor/LED PWM blocks and interrupt/event logic.

Parameters:
- bitwidth, 16, width of counter, reload and each compare value.
- prescaler_bitwidth, 8, width of prescaler register.
- channels, 2, number of compare/PWM channels (1..8).

Ports:
- clock  input  1  counter clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low; low clears all state immediately.
- start  input  1  rising edge (internally edge-detected) starts or restarts counting.
- stop  input  1  rising edge (internally edge-detected) stops counting.
- mode  input  2  0=up, 1=down, 2=centre-aligned, 3=reserved (treated as up).
- autoreload  input  1  1=periodic, 0=one-shot.
- prescaler  input  prescaler_bitwidth  counter advances every prescaler+1 clocks.
- reload_value  input  bitwidth  period top value.
- compare_values  input  channels*bitwidth  channel i at bits [i*bitwidth +: bitwidth].
- counting  output  1  high while running.
- value  output  bitwidth  current count.
- direction  output  1  0=up, 1=down.
- overflow  output  1  one-clock pulse on reaching the top.
- underflow  output  1  one-clock pulse on reaching zero when counting down.
- compare_match  output  channels  one-clock pulse per channel on match.
- pwm  output  channels  PWM level per channel.

Behaviour:
- Reset values: all outputs 0. Prescaler count, shadow registers and edge-detect history also 0.
- Shadow registers: active mode, prescaler, reload and compares.
  - Loaded from inputs on a start edge.
  - Loaded at every update event while autoreload=1.
  - Never loaded at any other time.
  - Input changes mid-period have no effect until the next update.
- Start with reload_value==0 is ignored; counting stays 0.
- Start edge sampled in cycle n, in cycle n+1:
  - counting=1;
  - value = 0 for up/centre, reload for down;
  - direction = 0 for up/centre, 1 for down;
  - prescaler count = 0.
- Start while counting: restarts the same way; no overflow or underflow pulse.
- Stop edge: counting=0 next cycle; value holds its current count.
- Simultaneous start and stop edges: stop wins.
- Tick: asserted when counting and prescaler count == active prescaler.
  - The prescaler count then returns to 0; otherwise it increments.
  - value changes only on ticks.
- Up mode, on a tick:
  - value==reload: value←0, overflow pulse, update event;
  - otherwise value+1.
- Down mode, on a tick:
  - value==0: value←reload, underflow pulse, update event;
  - otherwise value−1.
- Centre mode, on a tick:
  - climbs 0→reload; at reload: overflow pulse, direction←1, value reload−1;
  - descends to 0; at 0: underflow pulse, direction←0, value 1;
  - update event only at the 0 turnaround;
  - reload==1 toggles 0↔1.
- One-shot (autoreload=0): at the first update event counting←0 and value←0 (up/centre) or reload (down). The overflow/underflow pulse still fires.
- Counter arithmetic wraps modulo 2^bitwidth, but the terminal checks above prevent wrap.
- compare_match[i]: one-clock pulse in the cycle after a tick whose new value equals active compare[i].
- pwm[i] = counting && (value < active compare[i]); registered with value.
  - compare 0 gives constant low.
  - compare > reload gives constant high while counting.
- Reset low mid-operation: everything returns to reset values asynchronously. Counting resumes only on a new start edge after reset release.

Decomposition:
- Shared package/header timer_counter_defines: mode encodings (MODE_UP, MODE_DOWN, MODE_CENTER), direction constants.
- Sub-module compare_channel, instantiated channels times via generate. It holds the compare shadow register and produces compare_match and pwm from value, tick and the update event.

Test Plan:
- Up, prescaler=0, reload=4, autoreload=1, start pulse → value 0,1,2,3,4,0… one step per clock; overflow pulse when value returns to 0, every 5 clocks.
- Down, prescaler=2, reload=3, one-shot → value 3,2,1,0 stepping every 3 clocks; underflow pulse once; counting→0; value back to 3.
- Centre, reload=3, compare0=2 → value 0,1,2,3,2,1,0,1…; overflow at the 3 turnaround, underflow at the 0 turnaround; pwm0 high while value<2; compare_match0 pulses twice per period.
- Change reload 4→7 mid-period in up/autoreload → current period still ends at 4; next period counts to 7.
- Start and stop rising in the same cycle while idle → counting stays 0. Start with reload_value=0 → counting stays 0.
- Assert reset low while value=3 and counting → all outputs 0 immediately, no clock edge needed. After release, no counting until a new start edge.
